// File: rtl/sensor_sched_pkg.sv
// sensor_sched_pkg: command/response codes and FSM states shared by the sensor request scheduler
package sensor_sched_pkg;
    localparam logic [7:0] READ_TEMP        = 8'h01;
    localparam logic [7:0] READ_HUM         = 8'h02;
    localparam logic [7:0] CONT_TEMP_ON     = 8'h03;
    localparam logic [7:0] CONT_HUM_ON      = 8'h04;
    localparam logic [7:0] CONT_TEMP_OFF    = 8'h05;
    localparam logic [7:0] CONT_HUM_OFF     = 8'h06;
    localparam logic [7:0] RSP_TIMEOUT      = 8'hE0;
    localparam logic [7:0] RSP_INVALID      = 8'hE1;
    localparam logic [7:0] RSP_CONT_OFF_ACK = 8'h0A;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SENSOR, RESPOND, WAIT_TX} state_t;
endpackage

// File: rtl/rr_bit_picker.sv
// rr_bit_picker: finds the first set bit at or after ptr, wrapping around
// Ports: bits (candidate vector), ptr (search start), found (any bit set), sel (chosen index)
module rr_bit_picker #(
    parameter int WIDTH = 64,
    parameter int PW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    input  logic [PW-1:0]    ptr,
    output logic             found,
    output logic [PW-1:0]    sel
);
    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        sel = '0;
        for (int k = WIDTH - 1; k >= 0; k--)
            if (bits[PW'((int'(ptr) + k) % WIDTH)]) sel = PW'((int'(ptr) + k) % WIDTH);
    end
    assign found = |bits;
endmodule

// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: sequences PC requests and continuous polls to the sensor link, one at a time
// Ports: clock/reset (sync, active-high); req_* from uart_rx; sensor_* to/from conexao_sensor;
//        tx_* to/from uart_tx; continuous_active (any monitoring bit set); overflow (sticky drop flag).
// Optional: define SCHED_STATS_EN to add done_count/timeout_count saturating counters.
module sensor_request_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int NUM_SENSORS        = 32,
    parameter int POLL_PERIOD_CYCLES = 50_000_000,
    parameter int TIMEOUT_CYCLES     = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_command,
    input  logic [7:0] req_address,
    output logic       sensor_start,
    output logic [7:0] sensor_command,
    output logic [7:0] sensor_address,
    input  logic       sensor_done,
    input  logic [7:0] sensor_rsp_command,
    input  logic [7:0] sensor_rsp_value,
    output logic       tx_start,
    output logic [7:0] tx_command,
    output logic [7:0] tx_value,
    input  logic       tx_done,
    output logic       continuous_active,
    output logic       overflow
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] done_count,
    output logic [15:0] timeout_count
`endif
);
    localparam int NB = 2 * NUM_SENSORS;
    localparam int PW = $clog2(NB);

    state_t          state;
    logic            buf_valid, poll_pending;
    logic [7:0]      buf_cmd, buf_addr;
    logic [NB-1:0]   bitmap, cont_mask;
    logic [31:0]     poll_cnt, to_cnt;
    logic [PW-1:0]   rr_ptr, pick_sel, next_ptr, bit_idx;
    logic            pick_found, poll_hum, is_cont, cont_on, cont_hum, addr_ok, timeout_hit;

    rr_bit_picker #(.WIDTH(NB)) u_pick (
        .bits (bitmap),
        .ptr  (rr_ptr),
        .found(pick_found),
        .sel  (pick_sel)
    );

    assign is_cont     = buf_cmd >= CONT_TEMP_ON && buf_cmd <= CONT_HUM_OFF;
    assign cont_on     = buf_cmd == CONT_TEMP_ON || buf_cmd == CONT_HUM_ON;
    assign cont_hum    = buf_cmd == CONT_HUM_ON || buf_cmd == CONT_HUM_OFF;
    assign addr_ok     = {24'd0, buf_addr} < 32'(NUM_SENSORS);
    // Humidity bits live in the upper half of the bitmap.
    assign bit_idx     = PW'(buf_addr) + (cont_hum ? PW'(NUM_SENSORS) : '0);
    assign cont_mask   = NB'(1) << bit_idx;
    assign poll_hum    = pick_sel >= PW'(NUM_SENSORS);
    assign next_ptr    = pick_sel == PW'(NB - 1) ? '0 : pick_sel + 1'b1;
    // to_cnt is zero during ISSUE and counts from there, so the timeout fires
    // TIMEOUT_CYCLES cycles after sensor_start.
    assign timeout_hit = state == WAIT_SENSOR && !sensor_done && to_cnt == 32'(TIMEOUT_CYCLES - 1);

    assign sensor_start      = state == ISSUE;
    assign tx_start          = state == RESPOND;
    assign continuous_active = |bitmap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            buf_valid      <= 1'b0;
            buf_cmd        <= '0;
            buf_addr       <= '0;
            bitmap         <= '0;
            poll_cnt       <= '0;
            poll_pending   <= 1'b0;
            rr_ptr         <= '0;
            to_cnt         <= '0;
            sensor_command <= '0;
            sensor_address <= '0;
            tx_command     <= '0;
            tx_value       <= '0;
            overflow       <= 1'b0;
        end else begin
            to_cnt <= state == IDLE ? '0 : to_cnt + 1'b1;
            if (req_valid) begin
                if (buf_valid) overflow <= 1'b1;
                else {buf_valid, buf_cmd, buf_addr} <= {1'b1, req_command, req_address};
            end
            case (state)
                IDLE: begin
                    if (buf_valid) begin
                        buf_valid <= 1'b0;
                        if (is_cont && !addr_ok) begin
                            tx_command <= RSP_INVALID;
                            tx_value   <= buf_addr;
                            state      <= RESPOND;
                        end else if (is_cont && !cont_on) begin
                            bitmap     <= bitmap & ~cont_mask;
                            tx_command <= RSP_CONT_OFF_ACK;
                            tx_value   <= buf_addr;
                            state      <= RESPOND;
                        end else begin
                            if (cont_on) bitmap <= bitmap | cont_mask;
                            sensor_command <= !is_cont ? buf_cmd : cont_hum ? READ_HUM : READ_TEMP;
                            sensor_address <= buf_addr;
                            state          <= ISSUE;
                        end
                    end else if (poll_pending) begin
                        // A tick left over after the bitmap emptied is simply discarded.
                        poll_pending <= 1'b0;
                        if (pick_found) begin
                            sensor_command <= poll_hum ? READ_HUM : READ_TEMP;
                            sensor_address <= 8'(poll_hum ? pick_sel - PW'(NUM_SENSORS) : pick_sel);
                            rr_ptr         <= next_ptr;
                            state          <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT_SENSOR;
                WAIT_SENSOR: begin
                    if (sensor_done) begin
                        tx_command <= sensor_rsp_command;
                        tx_value   <= sensor_rsp_value;
                        state      <= RESPOND;
                    end else if (timeout_hit) begin
                        tx_command <= RSP_TIMEOUT;
                        tx_value   <= sensor_address;
                        state      <= RESPOND;
                    end
                end
                RESPOND: state <= WAIT_TX;
                WAIT_TX: state <= tx_done ? IDLE : WAIT_TX;
                default: state <= IDLE;
            endcase
            // Placed after the FSM so a fresh tick wins over a same-cycle poll issue.
            if (poll_cnt == 32'(POLL_PERIOD_CYCLES - 1)) begin
                poll_cnt <= '0;
                if (|bitmap) poll_pending <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            done_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (state == WAIT_TX && tx_done && done_count != 16'hFFFF) done_count <= done_count + 1'b1;
            if (timeout_hit && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 1'b1;
        end
    end
`endif
endmodule

// File: doc/sensor_request_scheduler.md
Name: sensor_request_scheduler

Overview:
Sits between uart_rx and conexao_sensor and sequences every sensor access, one at a time. It arbitrates between PC requests and autonomous continuous-monitoring polls. It holds the per-sensor continuous-mode bitmap and handles sensor timeouts. It passes each response to uart_tx and waits for transmit completion before starting the next transaction.

Parameters:
NUM_SENSORS, 32, number of addressable sensors (addresses 0..NUM_SENSORS-1)
POLL_PERIOD_CYCLES, 50_000_000, clock cycles between continuous-poll ticks (1 s at 50 MHz)
TIMEOUT_CYCLES, 5_000_000, maximum wait for sensor_done before a timeout response

Ports:
clock  in  1  50 MHz system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  one-cycle pulse from uart_rx: request bytes valid
req_command  in  8  request command byte
req_address  in  8  request sensor address
sensor_start  out  1  one-cycle pulse to conexao_sensor
sensor_command  out  8  command to sensor connection
sensor_address  out  8  address to sensor connection
sensor_done  in  1  one-cycle pulse: sensor response valid
sensor_rsp_command  in  8  response command from sensor connection
sensor_rsp_value  in  8  response value from sensor connection
tx_start  out  1  one-cycle pulse to uart_tx
tx_command  out  8  response command byte to PC
tx_value  out  8  response value byte to PC
tx_done  in  1  one-cycle pulse: uart_tx finished both bytes
continuous_active  out  1  OR of the continuous bitmap
overflow  out  1  sticky: a PC request was dropped

Behaviour:
- Reset:
  - All outputs are 0.
  - Bitmap, pending buffer, poll counter, timeout counter and round-robin pointer are cleared.
  - State is IDLE.
  - A reset mid-transaction abandons it silently; no response is sent.
- Commands:
  - READ_TEMP = 0x01, READ_HUM = 0x02.
  - CONT_TEMP_ON = 0x03, CONT_HUM_ON = 0x04, CONT_TEMP_OFF = 0x05, CONT_HUM_OFF = 0x06.
  - Any other value passes through to the sensor unchanged.
- Pending buffer:
  - One entry. req_valid captures the command and address whenever the buffer is empty, in any state.
  - If req_valid arrives while the buffer is full, the request is dropped and overflow is set until reset.
- Poll tick:
  - The counter runs 0..POLL_PERIOD_CYCLES-1. At wrap, poll_pending is set if the bitmap is non-zero.
  - poll_pending clears when a poll is issued.
  - Poll counting never stalls.
- Arbitration in IDLE: pending PC request first, then poll_pending.
  - A poll selects the next set bit of the 2*NUM_SENSORS bitmap at or after the rr pointer, with wrap-around.
  - Bit index i means: i < NUM_SENSORS is temperature for sensor i; otherwise humidity for sensor i-NUM_SENSORS.
  - After a poll is issued, the pointer advances to the selected bit + 1 (mod 2*NUM_SENSORS).
- FSM states: IDLE, ISSUE, WAIT_SENSOR, RESPOND, WAIT_TX.
  - IDLE -> ISSUE: when a request is selected.
  - ISSUE: sensor_start = 1 for exactly one cycle, command/address stable, timeout counter cleared; -> WAIT_SENSOR.
  - WAIT_SENSOR, sensor_done: latch the response; -> RESPOND.
  - WAIT_SENSOR, counter reaches TIMEOUT_CYCLES-1: response = (0xE0, address); -> RESPOND.
  - RESPOND: tx_start = 1 for one cycle; tx_command and tx_value hold until tx_done; -> WAIT_TX.
  - WAIT_TX, tx_done: -> IDLE.
  - A sensor_done arriving outside WAIT_SENSOR is ignored.
- Continuous-mode commands from the PC:
  - Address >= NUM_SENSORS: response (0xE1, address) goes straight to RESPOND; no sensor access.
  - CONT_*_ON: set the bit, then issue the matching READ_* to the sensor and forward its response.
  - CONT_*_OFF: clear the bit; response (0x0A, address) goes straight to RESPOND.
  - Bitmap updates occur at dispatch from IDLE.
- Polls issue READ_TEMP or READ_HUM.
- Latency: a req_valid at edge N with the FSM in IDLE and the buffer empty gives sensor_start during cycle N+2.

Optional Feature:
SCHED_STATS_EN
- Defined: adds output ports done_count[15:0] (increments when a transaction completes via tx_done) and timeout_count[15:0] (increments on each timeout). Both saturate at 0xFFFF and clear on reset.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sensor_sched_pkg holds:
  - command constants 0x01..0x06;
  - response constants RSP_TIMEOUT = 0xE0, RSP_INVALID = 0xE1, RSP_CONT_OFF_ACK = 0x0A;
  - the FSM state enum.
- Sub-module rr_bit_picker: combinational find-next-set-bit from a pointer with wrap-around, 2*NUM_SENSORS wide.

Test Plan:
- PC READ_TEMP addr 0x00; sensor_done two cycles after sensor_start with (0x01, 0x19) -> sensor_start at N+2; tx_start once with (0x01, 0x19); IDLE after tx_done.
- CONT_TEMP_ON addr 0x02, POLL_PERIOD_CYCLES = 100 -> immediate READ_TEMP addr 2; then every 100 cycles sensor_start with (0x01, 0x02); continuous_active = 1. CONT_TEMP_OFF addr 0x02 -> response (0x0A, 0x02) with no sensor_start; polls stop.
- CONT_HUM_ON for addrs 1 and 3, poll tick -> polls alternate between addr 1 and addr 3 in round-robin order.
- PC request and poll tick in the same cycle -> PC request served first; the poll follows after tx_done.
- Sensor never responds, TIMEOUT_CYCLES = 50 -> tx (0xE0, address) 50 cycles after sensor_start; next request proceeds.
- Three req_valid pulses while a transaction is in flight -> first buffered, others dropped, overflow = 1. Address 0x40 with CONT_TEMP_ON -> (0xE1, 0x40). Reset mid-WAIT_SENSOR -> all outputs 0, no tx_start.
